// File: rtl/delay_measure_pkg.sv
// Shared types and default constants for the delay-measurement block,
// reused by the top, the marker detector and the bench.
package delay_measure_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [7:0]  DEF_MARKER    = 8'hA5;
  localparam logic [7:0]  DEF_IDLE_BYTE = 8'h00;
  localparam int unsigned DEF_MAX_WAIT  = 32'd255;

endpackage

// File: rtl/delay_measure_if.sv
// Probe/result bus of the delay-measurement block; the slave side is the
// measuring block, the master side drives start and closes the loop.
interface delay_measure_if;

  logic       start;
  logic [7:0] rx_data;
  logic [7:0] tx_data;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [7:0] delay_cnt;

  modport master (
    output start,
    output rx_data,
    input  tx_data,
    input  busy,
    input  done,
    input  timeout,
    input  delay_cnt
  );

  modport slave (
    input  start,
    input  rx_data,
    output tx_data,
    output busy,
    output done,
    output timeout,
    output delay_cnt
  );

endinterface

// File: rtl/delay_measure_marker_detect.sv
// Rising-match detector: flags the first cycle rx_data equals the marker,
// so a marker that is already present is never counted as an arrival.
module marker_detect
  import delay_measure_pkg::*;
#(
  parameter logic [7:0] MARKER    = DEF_MARKER,
  parameter logic [7:0] IDLE_BYTE = DEF_IDLE_BYTE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_rx_data,
  output logic       o_match
);

  logic [7:0] r_rx_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_prev <= IDLE_BYTE;
    end else begin
      r_rx_prev <= i_rx_data;
    end
  end

  assign o_match = (i_rx_data == MARKER) && (r_rx_prev != MARKER);

endmodule

// File: rtl/delay_measure.sv
// Round-trip delay meter: sends one marker byte into the path under test and
// counts clk cycles until it returns, or flags a timeout after MAX_WAIT.
module delay_measure
  import delay_measure_pkg::*;
#(
  parameter logic [7:0]  MARKER    = DEF_MARKER,
  parameter logic [7:0]  IDLE_BYTE = DEF_IDLE_BYTE,
  parameter int unsigned MAX_WAIT  = DEF_MAX_WAIT
) (
  input  logic           clk,
  input  logic           rst_n,
  delay_measure_if.slave bus
);

  localparam logic [7:0] C_MAX_WAIT = 8'(MAX_WAIT);

  state_t     r_state;
  state_t     w_state_nx;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nx;
  logic [7:0] r_delay_cnt;
  logic [7:0] w_delay_nx;
  logic       r_timeout;
  logic       w_timeout_nx;
  logic [7:0] r_tx_data;
  logic       r_busy;
  logic       r_done;
  logic       w_match;

  marker_detect #(
    .MARKER    (MARKER),
    .IDLE_BYTE (IDLE_BYTE)
  ) u_marker_detect (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_rx_data (bus.rx_data),
    .o_match   (w_match)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Detection outranks the timeout when both land on the last count.
  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_delay_nx   = r_delay_cnt;
    w_timeout_nx = r_timeout;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nx = ST_SEND;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_SEND: begin
        w_cnt_nx   = 8'd1;
        w_state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_match) begin
          w_delay_nx   = r_cnt;
          w_timeout_nx = 1'b0;
          w_state_nx   = ST_DONE;
        end else if (r_cnt == C_MAX_WAIT) begin
          w_delay_nx   = 8'd0;
          w_timeout_nx = 1'b1;
          w_state_nx   = ST_DONE;
        end else begin
          w_cnt_nx = r_cnt + 8'd1;
        end
      end
      ST_DONE: begin
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= 8'd0;
      r_delay_cnt <= 8'd0;
      r_timeout   <= 1'b0;
      r_tx_data   <= IDLE_BYTE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nx;
      r_delay_cnt <= w_delay_nx;
      r_timeout   <= w_timeout_nx;
      r_tx_data   <= (w_state_nx == ST_SEND) ? MARKER : IDLE_BYTE;
      r_busy      <= (w_state_nx != ST_IDLE);
      r_done      <= (w_state_nx == ST_DONE);
    end
  end

  assign bus.tx_data   = r_tx_data;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.timeout   = r_timeout;
  assign bus.delay_cnt = r_delay_cnt;

endmodule

// File: doc/delay_measure.md
DELAY_MEASURE -- requirements
Module: delay_measure

Interface
REQ-001 SHALL have parameter MARKER, default 8'hA5, the probe byte sent into the delay path.
REQ-002 SHALL have parameter IDLE_BYTE, default 8'h00, the byte driven on tx_data when no probe is sent.
REQ-003 SHALL have parameter MAX_WAIT, default 255, the last count checked before timeout (range 2..255).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 start  input  1  request one measurement; sampled only in IDLE.
REQ-007 rx_data  input  8  byte returning from the delay path under test.
REQ-008 tx_data  output  8  byte driven into the delay path under test.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse when a measurement completes.
REQ-011 timeout  output  1  result flag: last measurement found no marker.
REQ-012 delay_cnt  output  8  result: measured delay in clk cycles.

Function
REQ-013 SHALL implement FSM states IDLE, SEND, WAIT, DONE.
REQ-014 IDLE: tx_data=IDLE_BYTE; start=1 -> SEND next cycle; start in any other state is ignored, with no queuing.
REQ-015 SEND, exactly one cycle: tx_data=MARKER; cnt loaded to 1; -> WAIT.
REQ-016 WAIT: tx_data=IDLE_BYTE; the marker is detected when rx_data==MARKER and the rx_data of the previous cycle !=MARKER (rising-match edge).
REQ-017 WAIT on detect: delay_cnt<=cnt, timeout<=0, -> DONE.
REQ-018 WAIT with no detect and cnt==MAX_WAIT: delay_cnt<=0, timeout<=1, -> DONE.
REQ-019 WAIT otherwise: cnt<=cnt+1. cnt is 8 bits and never wraps, because of REQ-018.
REQ-020 Detect and cnt==MAX_WAIT in the same cycle: detect wins (delay_cnt=MAX_WAIT, timeout=0).
REQ-021 DONE, one cycle: done=1; -> IDLE.
REQ-022 Latency: a path of N registers (1<=N<=MAX_WAIT) SHALL yield delay_cnt=N. Total time from start to done SHALL be N+2 cycles.
REQ-023 A marker is not checked during the SEND cycle, so N=0 (combinational loopback) SHALL report timeout.
REQ-024 delay_cnt and timeout SHALL hold their values from DONE until the next DONE. They SHALL NOT be cleared on start.
REQ-025 If rx_data already equals MARKER when WAIT is entered, that value SHALL NOT match; stale markers therefore cannot produce false results.
REQ-026 tx_data, busy and done SHALL be registered outputs or decoded from state only; they SHALL NOT be combinational paths from inputs.

Reset
REQ-027 Asserting rst_n low SHALL immediately force: state=IDLE, tx_data=IDLE_BYTE, busy=0, done=0, timeout=0, delay_cnt=0, cnt=0, previous-rx register=IDLE_BYTE.
REQ-028 Reset during SEND/WAIT SHALL abort the measurement and produce no done pulse. The first start after release SHALL be honoured.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (2 bits) and the default MARKER / IDLE_BYTE / MAX_WAIT constants, for reuse by the delay-line top and bench.
REQ-030 A single sub-module, marker_detect, SHALL be used: it contains the previous-rx register and the edge-match logic of REQ-016. The FSM, counter and result registers stay in delay_measure.

Verification
REQ-031 Loopback through registered delay models of N=30, 45, 60, 90, one start each -> delay_cnt=30, 45, 60, 90; timeout=0; done exactly N+2 cycles after start.
REQ-032 rx_data tied to 8'h00, start -> timeout=1, delay_cnt=0, done at cycle MAX_WAIT+2 (257).
REQ-033 rx_data tied to MARKER permanently, start -> no detect, timeout=1 (stale-marker rejection).
REQ-034 N=30 loopback with start re-pulsed in cycles 5 and 20 of WAIT -> single result delay_cnt=30, only one done pulse.
REQ-035 N=45 loopback with rst_n low for 1 cycle at WAIT cycle 10 -> all outputs at reset values and no done; the subsequent start then yields delay_cnt=45.
REQ-036 N=1 and N=MAX_WAIT loopbacks -> delay_cnt=1 and delay_cnt=255 respectively, timeout=0 in both.
